// File: rtl/mem128k_ctrl.sv
// Single-word SRAM initiator: SETUP/ACCESS/HOLD strobe sequencing, RSP_VALID S+A+H cycles after acceptance.
// Backpressure: REQ_READY high only in IDLE; requests presented while busy are ignored.
module mem128k_ctrl #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [14:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic [14:0] MEM_A,
  output logic [31:0] MEM_D_WRITE,
  input  logic [31:0] MEM_D_READ,
  output logic        MEM_CS,
  output logic        MEM_OE,
  output logic        MEM_WE
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] ACCESS_LD = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [14:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_q, rsp_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          wr_d    = REQ_WE;
          addr_d  = REQ_ADDR;
          if (REQ_WE) wdata_d = REQ_WDATA;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          // Sample on the edge leaving ACCESS, after OE has been low for the full access time
          if (!wr_q) rdata_d = MEM_D_READ;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          rsp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Strobes are decoded from the next state so the pins themselves come straight from flops
    cs_d = (state_d == IDLE);
    oe_d = !((state_d == ACCESS) && !wr_d);
    we_d = !((state_d == ACCESS) && wr_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= 15'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      rsp_q   <= 1'b0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
    end
  end

  assign REQ_READY   = (state_q == IDLE);
  assign RSP_VALID   = rsp_q;
  assign RSP_RDATA   = rdata_q;
  assign MEM_A       = addr_q;
  assign MEM_D_WRITE = wdata_q;
  assign MEM_CS      = cs_q;
  assign MEM_OE      = oe_q;
  assign MEM_WE      = we_q;

endmodule

// File: tb/tb_mem128k_ctrl.sv
// Directed bench: default-timing controller against a word-memory model, plus a 2/5/3 timing instance.
module tb_mem128k_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default timing
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [14:0] req_addr = 15'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        ready1, rsp1, cs1, oe1, we1;
  logic [31:0] rdata1, dw1, dr1;
  logic [14:0] a1;

  // Instance 2: SETUP=2, ACCESS=5, HOLD=3
  logic        req2_valid = 1'b0, req2_we = 1'b0;
  logic [14:0] req2_addr = 15'd0;
  logic [31:0] req2_wdata = 32'd0;
  logic        ready2, rsp2, cs2, oe2, we2;
  logic [31:0] rdata2, dw2, dr2;
  logic [14:0] a2;

  mem128k_ctrl dut1 (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(ready1), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp1), .RSP_RDATA(rdata1),
    .MEM_A(a1), .MEM_D_WRITE(dw1), .MEM_D_READ(dr1),
    .MEM_CS(cs1), .MEM_OE(oe1), .MEM_WE(we1)
  );

  mem128k_ctrl #(.SETUP_CYCLES(2), .ACCESS_CYCLES(5), .HOLD_CYCLES(3)) dut2 (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req2_valid), .REQ_READY(ready2), .REQ_WE(req2_we),
    .REQ_ADDR(req2_addr), .REQ_WDATA(req2_wdata),
    .RSP_VALID(rsp2), .RSP_RDATA(rdata2),
    .MEM_A(a2), .MEM_D_WRITE(dw2), .MEM_D_READ(dr2),
    .MEM_CS(cs2), .MEM_OE(oe2), .MEM_WE(we2)
  );

  // Word memory for instance 1
  logic [31:0] mem [0:32767];
  always @(posedge clk) if (!cs1 && !we1) mem[a1] <= dw1;
  assign dr1 = (!cs1 && !oe1) ? mem[a1] : 32'h0;

  // Instance 2 memory returns a value that changes every OE-low cycle, exposing the sample point
  logic [4:0] oe_run = 5'd0;
  always @(posedge clk) oe_run <= oe2 ? 5'd0 : oe_run + 5'd1;
  assign dr2 = oe2 ? 32'h0 : (32'h1357_0000 | {27'd0, oe_run});

  // Strobe legality monitor
  bit mon_en = 1'b0;
  int ovl = 0;
  always @(negedge clk) if (mon_en) begin
    if (!oe1 && !we1) ovl++;
    if (cs1 && (!oe1 || !we1)) ovl++;
    if (!oe2 && !we2) ovl++;
    if (cs2 && (!oe2 || !we2)) ovl++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance 1 and record cycles 1..6 after acceptance (bit i = cycle i+1)
  task automatic run1(input logic we, input logic [14:0] a, input logic [31:0] d,
                      output logic [5:0] cs_t, output logic [5:0] oe_t,
                      output logic [5:0] we_t, output logic [5:0] rv_t,
                      output logic [31:0] rd5);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rd5 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      cs_t[i] = cs1; oe_t[i] = oe1; we_t[i] = we1; rv_t[i] = rsp1;
      if (i == 4) rd5 = rdata1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [5:0]  cs_t, oe_t, we_t, rv_t;
    logic [31:0] rd5;
    int oe_cnt, oe_first, rsp_cnt, rsp_at, a_bad;

    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'd0, ready1}, 32'd1);
    chk("rst_rsp", {31'd0, rsp1}, 32'd0);
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_addr", {17'd0, a1}, 32'd0);
    chk("rst_wdata", dw1, 32'd0);
    chk("rst_strobes", {29'd0, cs1, oe1, we1}, 32'd7);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Default write
    run1(1'b1, 15'h1234, 32'hDEADBEEF, cs_t, oe_t, we_t, rv_t, rd5);
    chk("wr_cs", {26'd0, cs_t}, 32'b110000);
    chk("wr_we", {26'd0, we_t}, 32'b111001);
    chk("wr_oe", {26'd0, oe_t}, 32'b111111);
    chk("wr_rsp", {26'd0, rv_t}, 32'b010000);
    chk("wr_addr", {17'd0, a1}, 32'h1234);
    chk("wr_dw", dw1, 32'hDEADBEEF);
    chk("wr_rdata_kept", rd5, 32'd0);

    // Default read of the same word
    run1(1'b0, 15'h1234, 32'h0, cs_t, oe_t, we_t, rv_t, rd5);
    chk("rd_cs", {26'd0, cs_t}, 32'b110000);
    chk("rd_oe", {26'd0, oe_t}, 32'b111001);
    chk("rd_we", {26'd0, we_t}, 32'b111111);
    chk("rd_rsp", {26'd0, rv_t}, 32'b010000);
    chk("rd_data", rd5, 32'hDEADBEEF);

    // Back-to-back write then read with REQ_VALID held high
    req_we = 1'b1; req_addr = 15'h0042; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    tick();
    chk("b2b_busy", {31'd0, ready1}, 32'd0);
    repeat (4) tick();
    chk("b2b_w_rsp", {31'd0, rsp1}, 32'd1);
    chk("b2b_w_ready", {31'd0, ready1}, 32'd1);
    req_we = 1'b0;
    tick();
    chk("b2b_r_accepted", {31'd0, ready1}, 32'd0);
    chk("b2b_r_cs", {31'd0, cs1}, 32'd0);
    req_valid = 1'b0;
    repeat (4) tick();
    chk("b2b_r_rsp", {31'd0, rsp1}, 32'd1);
    chk("b2b_r_data", rdata1, 32'hCAFEF00D);
    chk("b2b_dw_kept", dw1, 32'hCAFEF00D);
    tick();

    // Requests toggled while busy are ignored
    req_we = 1'b0; req_addr = 15'h1234; req_valid = 1'b1;
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h0555;
    tick();
    chk("busy_a_c2", {17'd0, a1}, 32'h1234);
    req_valid = 1'b0;
    tick();
    chk("busy_a_c3", {17'd0, a1}, 32'h1234);
    req_valid = 1'b1;
    tick();
    chk("busy_a_c4", {17'd0, a1}, 32'h1234);
    req_valid = 1'b0;
    tick();
    chk("busy_rsp", {31'd0, rsp1}, 32'd1);
    chk("busy_rdata", rdata1, 32'hDEADBEEF);
    chk("busy_dw", dw1, 32'hCAFEF00D);
    tick();
    chk("busy_idle_a", {17'd0, a1}, 32'h1234);
    chk("busy_idle_cs", {31'd0, cs1}, 32'd1);

    // Reset during the ACCESS phase of a write
    req_we = 1'b1; req_addr = 15'h0077; req_wdata = 32'h11112222; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_we_low", {31'd0, we1}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_strobes", {29'd0, cs1, oe1, we1}, 32'd7);
    chk("abort_rsp", {31'd0, rsp1}, 32'd0);
    chk("abort_ready", {31'd0, ready1}, 32'd1);
    chk("abort_rdata", rdata1, 32'd0);
    chk("abort_addr", {17'd0, a1}, 32'd0);
    chk("abort_dw", dw1, 32'd0);
    tick();
    chk("abort_no_rsp", {31'd0, rsp1}, 32'd0);
    chk("abort_cs_idle", {31'd0, cs1}, 32'd1);

    // Next acceptance updates MEM_A
    req_we = 1'b0; req_addr = 15'h0555; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("next_accept_a", {17'd0, a1}, 32'h0555);
    repeat (5) tick();

    // Instance 2: long timing read of the top address
    req2_we = 1'b0; req2_addr = 15'h7FFF; req2_valid = 1'b1;
    tick();
    req2_valid = 1'b0;
    oe_cnt = 0; oe_first = 0; rsp_cnt = 0; rsp_at = 0; a_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (!oe2) begin
        oe_cnt++;
        if (oe_first == 0) oe_first = c;
      end
      if (rsp2) begin
        rsp_cnt++;
        rsp_at = c;
      end
      if (a2 !== 15'h7FFF) a_bad++;
    end
    chk("long_oe_cycles", oe_cnt, 32'd5);
    chk("long_oe_first", oe_first, 32'd3);
    chk("long_rsp_cycle", rsp_at, 32'd11);
    chk("long_rsp_count", rsp_cnt, 32'd1);
    chk("long_addr", a_bad, 32'd0);
    chk("long_rdata", rdata2, 32'h1357_0004);

    chk("strobe_overlap", ovl, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
